// File: rtl/fraction_dot_accum_if.sv
// Bundles the operand stream, multiplier link and result stream of fraction_dot_accum.
// The accumulator uses the slave view; the surrounding environment uses the master view.
interface fraction_dot_accum_if #(
  parameter int ACC_W = 10
);
  logic             In_Valid;
  logic             In_Ready;
  logic [3:0]       In_Mplier;
  logic [3:0]       In_Mcand;
  logic             In_Last;
  logic             Mul_St;
  logic [3:0]       Mul_Mplier;
  logic [3:0]       Mul_Mcand;
  logic [6:0]       Mul_Product;
  logic             Mul_Done;
  logic             Acc_Valid;
  logic             Acc_Ready;
  logic [ACC_W-1:0] Acc_Sum;
  logic [3:0]       Acc_Count;
  logic             Acc_Ovf;
  logic             Acc_Err;

  modport slave (
    input  In_Valid, In_Mplier, In_Mcand, In_Last, Mul_Product, Mul_Done, Acc_Ready,
    output In_Ready, Mul_St, Mul_Mplier, Mul_Mcand,
           Acc_Valid, Acc_Sum, Acc_Count, Acc_Ovf, Acc_Err
  );

  modport master (
    output In_Valid, In_Mplier, In_Mcand, In_Last, Mul_Product, Mul_Done, Acc_Ready,
    input  In_Ready, Mul_St, Mul_Mplier, Mul_Mcand,
           Acc_Valid, Acc_Sum, Acc_Count, Acc_Ovf, Acc_Err
  );
endinterface

// File: rtl/fraction_dot_accum.sv
// Sequences signed 4-bit fraction pairs through an external multiplier and sums the
// 7-bit products into a saturating dot-product accumulator, one result per burst.
module fraction_dot_accum #(
  parameter int ACC_W       = 10,
  parameter int MAX_TERMS   = 8,
  parameter int MUL_TIMEOUT = 15,
  parameter int RST_HOLD    = 8
) (
  input logic              CLK,
  input logic              Reset,
  fraction_dot_accum_if.slave bus
);
  typedef enum logic [2:0] {HOLD, IDLE, LAUNCH, WAIT, OUT} state_t;

  localparam int HOLD_W = $clog2(RST_HOLD + 1);
  localparam int TMO_W  = $clog2(MUL_TIMEOUT + 1);

  state_t             state_q, state_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic               last_q, last_d;
  logic               in_ready_q, in_ready_d;
  logic               mul_st_q, mul_st_d;
  logic [3:0]         mplier_q, mplier_d;
  logic [3:0]         mcand_q, mcand_d;
  logic               acc_valid_q, acc_valid_d;
  logic [ACC_W-1:0]   acc_sum_q, acc_sum_d;
  logic [3:0]         acc_count_q, acc_count_d;
  logic               acc_ovf_q, acc_ovf_d;
  logic               acc_err_q, acc_err_d;

  logic [ACC_W:0]     sum_wide;
  logic [ACC_W-1:0]   sum_sat;
  logic               sum_ovf;
  logic               term_done;

  // One guard bit detects signed overflow; the clamp direction follows the true sign.
  always_comb begin
    sum_wide = {acc_sum_q[ACC_W-1], acc_sum_q}
             + {{(ACC_W-6){bus.Mul_Product[6]}}, bus.Mul_Product};
    sum_ovf  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    if (!sum_ovf)
      sum_sat = sum_wide[ACC_W-1:0];
    else if (sum_wide[ACC_W])
      sum_sat = {1'b1, {(ACC_W-1){1'b0}}};
    else
      sum_sat = {1'b0, {(ACC_W-1){1'b1}}};
  end

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    last_d      = last_q;
    mplier_d    = mplier_q;
    mcand_d     = mcand_q;
    acc_sum_d   = acc_sum_q;
    acc_count_d = acc_count_q;
    acc_ovf_d   = acc_ovf_q;
    acc_err_d   = acc_err_q;
    term_done   = 1'b0;

    unique case (state_q)
      HOLD: begin
        if (hold_cnt_q == HOLD_W'(RST_HOLD - 1))
          state_d = IDLE;
        else
          hold_cnt_d = hold_cnt_q + 1'b1;
      end
      IDLE: begin
        if (bus.In_Valid && in_ready_q) begin
          mplier_d = bus.In_Mplier;
          mcand_d  = bus.In_Mcand;
          last_d   = bus.In_Last || (({1'b0, acc_count_q} + 5'd1) == 5'(MAX_TERMS));
          state_d  = LAUNCH;
        end
      end
      LAUNCH: begin
        tmo_cnt_d = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        // A Done arriving on the timeout cycle still counts as a real product.
        if (bus.Mul_Done) begin
          acc_sum_d   = sum_sat;
          acc_ovf_d   = acc_ovf_q | sum_ovf;
          acc_count_d = acc_count_q + 4'd1;
          term_done   = 1'b1;
        end else if (tmo_cnt_q == TMO_W'(MUL_TIMEOUT - 1)) begin
          acc_err_d   = 1'b1;
          acc_count_d = acc_count_q + 4'd1;
          term_done   = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
        if (term_done)
          state_d = last_q ? OUT : IDLE;
      end
      OUT: begin
        if (bus.Acc_Ready) begin
          acc_sum_d   = '0;
          acc_count_d = '0;
          acc_ovf_d   = 1'b0;
          acc_err_d   = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = HOLD;
    endcase

    // Status outputs are registered copies of the state being entered.
    in_ready_d  = (state_d == IDLE);
    mul_st_d    = (state_d == LAUNCH);
    acc_valid_d = (state_d == OUT);
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q     <= HOLD;
      hold_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
      last_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      mul_st_q    <= 1'b0;
      mplier_q    <= '0;
      mcand_q     <= '0;
      acc_valid_q <= 1'b0;
      acc_sum_q   <= '0;
      acc_count_q <= '0;
      acc_ovf_q   <= 1'b0;
      acc_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      last_q      <= last_d;
      in_ready_q  <= in_ready_d;
      mul_st_q    <= mul_st_d;
      mplier_q    <= mplier_d;
      mcand_q     <= mcand_d;
      acc_valid_q <= acc_valid_d;
      acc_sum_q   <= acc_sum_d;
      acc_count_q <= acc_count_d;
      acc_ovf_q   <= acc_ovf_d;
      acc_err_q   <= acc_err_d;
    end
  end

  assign bus.In_Ready   = in_ready_q;
  assign bus.Mul_St     = mul_st_q;
  assign bus.Mul_Mplier = mplier_q;
  assign bus.Mul_Mcand  = mcand_q;
  assign bus.Acc_Valid  = acc_valid_q;
  assign bus.Acc_Sum    = acc_sum_q;
  assign bus.Acc_Count  = acc_count_q;
  assign bus.Acc_Ovf    = acc_ovf_q;
  assign bus.Acc_Err    = acc_err_q;
endmodule

// File: tb/tb_fraction_dot_accum.sv
// Bench for fraction_dot_accum: a latency-programmable multiplier model plus a
// saturating dot-product reference, driven by directed and random bursts.
module tb_fraction_dot_accum;
  localparam int ACC_W       = 8;
  localparam int MAX_TERMS   = 8;
  localparam int MUL_TIMEOUT = 15;
  localparam int RST_HOLD    = 8;
  localparam int SMAX        = (1 << (ACC_W - 1)) - 1;
  localparam int SMIN        = -(1 << (ACC_W - 1));

  logic CLK = 1'b0;
  logic Reset;

  fraction_dot_accum_if #(.ACC_W(ACC_W)) bus ();

  fraction_dot_accum #(
    .ACC_W(ACC_W), .MAX_TERMS(MAX_TERMS), .MUL_TIMEOUT(MUL_TIMEOUT), .RST_HOLD(RST_HOLD)
  ) dut (
    .CLK(CLK),
    .Reset(Reset),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc     = 0;
  bit hung    = 1'b0;

  logic [3:0] op_a [MAX_TERMS];
  logic [3:0] op_b [MAX_TERMS];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int got, input int exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sx4(input logic [3:0] v);
    return int'($signed(v));
  endfunction

  // Multiplier model: Done pulses mul_lat cycles after the St cycle, unless hung.
  int         mul_lat  = 5;
  bit         mul_hang = 1'b0;
  int         mul_dly  = 0;
  int         st_cnt   = 0;
  int         st_cyc   = 0;
  logic [6:0] mul_pend = '0;

  always @(negedge CLK) begin
    bus.Mul_Done    = 1'b0;
    bus.Mul_Product = 7'($urandom);
    if (mul_dly > 0) begin
      mul_dly--;
      if (mul_dly == 0) begin
        bus.Mul_Done    = 1'b1;
        bus.Mul_Product = mul_pend;
      end
    end
    if (bus.Mul_St) begin
      st_cnt++;
      st_cyc   = cyc;
      mul_pend = 7'(sx4(bus.Mul_Mplier) * sx4(bus.Mul_Mcand));
      if (!mul_hang) mul_dly = mul_lat;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, " In_Ready"},   int'(bus.In_Ready),   0);
    check_eq({tag, " Mul_St"},     int'(bus.Mul_St),     0);
    check_eq({tag, " Mul_Mplier"}, int'(bus.Mul_Mplier), 0);
    check_eq({tag, " Mul_Mcand"},  int'(bus.Mul_Mcand),  0);
    check_eq({tag, " Acc_Valid"},  int'(bus.Acc_Valid),  0);
    check_eq({tag, " Acc_Sum"},    int'(bus.Acc_Sum),    0);
    check_eq({tag, " Acc_Count"},  int'(bus.Acc_Count),  0);
    check_eq({tag, " Acc_Ovf"},    int'(bus.Acc_Ovf),    0);
    check_eq({tag, " Acc_Err"},    int'(bus.Acc_Err),    0);
  endtask

  // Called at the first falling edge after the last reset edge.
  task automatic check_hold(input string tag);
    for (int i = 0; i < RST_HOLD; i++) begin
      check_eq($sformatf("%s hold%0d In_Ready", tag, i), int'(bus.In_Ready), 0);
      @(negedge CLK);
    end
    check_eq({tag, " ready after hold"}, int'(bus.In_Ready), 1);
    check_eq({tag, " count after hold"}, int'(bus.Acc_Count), 0);
    check_eq({tag, " sum after hold"},   int'(bus.Acc_Sum), 0);
  endtask

  task automatic send_pair(input string tag, input logic [3:0] a, input logic [3:0] b,
                           input bit last);
    int n = 0;
    if (hung) return;
    repeat ($urandom_range(0, 2)) @(negedge CLK);
    @(negedge CLK);
    bus.In_Valid  = 1'b1;
    bus.In_Mplier = a;
    bus.In_Mcand  = b;
    bus.In_Last   = last;
    while (!bus.In_Ready && n < 300) begin
      @(negedge CLK);
      n++;
    end
    if (!bus.In_Ready) begin
      check_eq({tag, " accept timeout"}, 0, 1);
      hung = 1'b1;
      bus.In_Valid = 1'b0;
      return;
    end
    @(posedge CLK);
    #1;
    bus.In_Valid  = 1'b0;
    bus.In_Mplier = 4'($urandom);
    bus.In_Mcand  = 4'($urandom);
    bus.In_Last   = 1'($urandom);
  endtask

  task automatic wait_result(input string tag, input int e_sum, input int e_cnt,
                             input int e_ovf, input int e_err, input int e_lat);
    int n = 0;
    if (hung) return;
    @(negedge CLK);
    while (!bus.Acc_Valid && n < 300) begin
      @(negedge CLK);
      n++;
    end
    if (!bus.Acc_Valid) begin
      check_eq({tag, " result timeout"}, 0, 1);
      hung = 1'b1;
      return;
    end
    check_eq({tag, " latency"},  cyc - st_cyc, e_lat);
    check_eq({tag, " sum"},      int'($signed(bus.Acc_Sum)), e_sum);
    check_eq({tag, " count"},    int'(bus.Acc_Count), e_cnt);
    check_eq({tag, " ovf"},      int'(bus.Acc_Ovf), e_ovf);
    check_eq({tag, " err"},      int'(bus.Acc_Err), e_err);
    repeat ($urandom_range(1, 3)) @(negedge CLK);
    check_eq({tag, " held sum"},   int'($signed(bus.Acc_Sum)), e_sum);
    check_eq({tag, " held count"}, int'(bus.Acc_Count), e_cnt);
    check_eq({tag, " held valid"}, int'(bus.Acc_Valid), 1);
    check_eq({tag, " ready in out"}, int'(bus.In_Ready), 0);
    bus.Acc_Ready = 1'b1;
    @(negedge CLK);
    bus.Acc_Ready = 1'b0;
    check_eq({tag, " valid cleared"}, int'(bus.Acc_Valid), 0);
    check_eq({tag, " count cleared"}, int'(bus.Acc_Count), 0);
    check_eq({tag, " sum cleared"},   int'(bus.Acc_Sum), 0);
    check_eq({tag, " err cleared"},   int'(bus.Acc_Err), 0);
    check_eq({tag, " ready again"},   int'(bus.In_Ready), 1);
  endtask

  // Reference: each term is the multiplier's 7-bit product (0 on timeout), summed with clamping.
  task automatic run_burst(input string tag, input int n, input bit use_last);
    int acc = 0;
    int ovf = 0;
    int err = 0;
    int st0;
    logic [6:0] p;
    bit tmo;
    tmo = mul_hang || (mul_lat > MUL_TIMEOUT);
    st0 = st_cnt;
    for (int i = 0; i < n; i++) begin
      p = 7'(sx4(op_a[i]) * sx4(op_b[i]));
      if (tmo) err = 1;
      else     acc = acc + int'($signed(p));
      if (acc > SMAX)      begin acc = SMAX; ovf = 1; end
      else if (acc < SMIN) begin acc = SMIN; ovf = 1; end
      send_pair(tag, op_a[i], op_b[i], use_last && (i == n - 1));
    end
    wait_result(tag, acc, n, ovf, err, tmo ? MUL_TIMEOUT + 1 : mul_lat + 1);
    if (!hung) check_eq({tag, " St pulses"}, st_cnt - st0, n);
  endtask

  task automatic fill(input logic [3:0] a, input logic [3:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      op_a[i] = a;
      op_b[i] = b;
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset         = 1'b1;
    bus.In_Valid  = 1'b0;
    bus.In_Mplier = '0;
    bus.In_Mcand  = '0;
    bus.In_Last   = 1'b0;
    bus.Acc_Ready = 1'b0;
    repeat (3) @(negedge CLK);
    check_reset_outputs("reset");
    Reset = 1'b0;
    check_hold("init");

    fill(4'b0100, 4'b0100, 4);
    run_burst("positive", 4, 1'b1);

    op_a[0] = 4'b1100; op_b[0] = 4'b0100;
    op_a[1] = 4'b0100; op_b[1] = 4'b0100;
    run_burst("signed_mix", 2, 1'b1);

    fill(4'b0111, 4'b0111, 3);
    run_burst("saturate", 3, 1'b1);

    fill(4'b1000, 4'b0111, 3);
    run_burst("saturate_neg", 3, 1'b1);

    for (int i = 0; i < MAX_TERMS; i++) begin
      op_a[i] = 4'($urandom);
      op_b[i] = 4'($urandom);
    end
    run_burst("implicit_last", MAX_TERMS, 1'b0);

    mul_hang = 1'b1;
    fill(4'b0011, 4'b0101, 1);
    run_burst("timeout", 1, 1'b1);
    mul_hang = 1'b0;

    mul_lat = MUL_TIMEOUT;
    fill(4'b0011, 4'b0101, 2);
    run_burst("done_at_timeout", 2, 1'b1);

    mul_lat = MUL_TIMEOUT + 1;
    fill(4'b0011, 4'b0101, 1);
    run_burst("late_done", 1, 1'b1);
    mul_lat = 5;

    // Reset while a multiplication is in flight; its Done lands inside HOLD.
    send_pair("mid_wait", 4'b0011, 4'b0101, 1'b0);
    repeat (2) @(negedge CLK);
    Reset = 1'b1;
    @(negedge CLK);
    Reset = 1'b0;
    check_reset_outputs("mid_wait");
    check_hold("mid_wait");
    fill(4'b0110, 4'b1101, 3);
    run_burst("after_reset", 3, 1'b1);

    for (int k = 0; k < 25; k++) begin
      int n;
      bit use_last;
      n        = $urandom_range(1, MAX_TERMS);
      use_last = (n < MAX_TERMS) ? 1'b1 : 1'($urandom);
      mul_lat  = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        op_a[i] = 4'($urandom);
        op_b[i] = 4'($urandom);
      end
      run_burst($sformatf("rand%0d", k), n, use_last);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
